control_pipeline: RTL and testbench

- Consumes the per-instruction control bundles (wb/mem/ex) produced by the ID-stage decoder.
- Carries each bundle through the ID/EX, EX/MEM and MEM/WB pipeline registers, dropping each field group once it has been used.
- Detects load-use hazards and inserts bubbles; flushes wrong-path instructions on a taken branch or jump.
- Drives the PC/IF-ID write enables and the stall/flush lines for the MIPS datapath.

---
 rtl/control_pipeline_pkg.sv | 32 +++
 rtl/control_pipeline_hazard.sv | 52 +++++
 rtl/control_pipeline.sv | 137 +++++++++++++
 tb/tb_control_pipeline.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pipeline_pkg.sv
// Shared definitions for the control pipeline: bit positions inside the
// wb/mem/ex control bundles, the bubble fill value and the squash reasons.
package control_pipeline_pkg;

    typedef enum int {
        MEMTOREG = 0,
        REGWRITE = 1
    } wb_bit_e;

    typedef enum int {
        MEMWRITE = 0,
        MEMREAD  = 1,
        BRANCH   = 2
    } mem_bit_e;

    typedef enum int {
        JUMP   = 4,
        ALUSRC = 5,
        REGDST = 6
    } ex_bit_e;

    // Why ID/EX is being loaded with a bubble this cycle.
    typedef enum logic [1:0] {
        SQUASH_NONE     = 2'd0,
        SQUASH_LOAD_USE = 2'd1,
        SQUASH_BRANCH   = 2'd2
    } squash_e;

    // A bubble is every control and register-address bit cleared.
    localparam logic BUBBLE_BIT = 1'b0;

endpackage

// File: rtl/control_pipeline_hazard.sv
// Load-use detection and taken-branch / jump flush arbitration for the
// ID stage. Purely combinational; a taken branch outranks a load-use stall.
module hazard_detection_unit
    import control_pipeline_pkg::*;
#(
    parameter int NB_REG_ADDR = 5
) (
    input  logic                   idex_mem_read,
    input  logic                   idex_branch,
    input  logic [NB_REG_ADDR-1:0] idex_rt,
    input  logic [NB_REG_ADDR-1:0] id_rs,
    input  logic [NB_REG_ADDR-1:0] id_rt,
    input  logic                   id_jump,
    input  logic                   alu_zero,
    output logic                   pc_write,
    output logic                   ifid_write,
    output logic                   flush_ifid,
    output logic                   pc_src_branch,
    output squash_e                squash
);

    logic load_use;
    logic branch_taken;

    // $zero is never written, so a load into it cannot create a dependency.
    assign load_use = idex_mem_read
                    && (idex_rt != '0)
                    && ((idex_rt == id_rs) || (idex_rt == id_rt));

    assign branch_taken = idex_branch && alu_zero;

    always_comb begin
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        flush_ifid    = 1'b0;
        pc_src_branch = 1'b0;
        squash        = SQUASH_NONE;
        if (branch_taken) begin
            pc_src_branch = 1'b1;
            flush_ifid    = 1'b1;
            squash        = SQUASH_BRANCH;
        end else if (load_use) begin
            // The stalled jump stays in IF/ID, so its flush waits for the retry.
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            squash     = SQUASH_LOAD_USE;
        end else if (id_jump) begin
            flush_ifid = 1'b1;
        end
    end

endmodule

// File: rtl/control_pipeline.sv
// Control-path pipeline registers (ID/EX, EX/MEM, MEM/WB) for the MIPS
// datapath, with bubble insertion for load-use stalls and branch flushes.
module control_pipeline
    import control_pipeline_pkg::*;
#(
    parameter int NB_CTRL_WB  = 2,
    parameter int NB_CTRL_MEM = 3,
    parameter int NB_CTRL_EX  = 7,
    parameter int NB_REG_ADDR = 5,
    parameter int NB_COUNT    = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_enable,
    input  logic [NB_CTRL_WB-1:0]  i_ctrl_wb,
    input  logic [NB_CTRL_MEM-1:0] i_ctrl_mem,
    input  logic [NB_CTRL_EX-1:0]  i_ctrl_ex,
    input  logic [NB_REG_ADDR-1:0] i_id_rs,
    input  logic [NB_REG_ADDR-1:0] i_id_rt,
    input  logic [NB_REG_ADDR-1:0] i_id_rd,
    input  logic                   i_alu_zero,
    output logic [NB_CTRL_EX-1:0]  o_ex_ctrl,
    output logic [NB_REG_ADDR-1:0] o_ex_rt,
    output logic [NB_CTRL_MEM-1:0] o_mem_ctrl,
    output logic [NB_REG_ADDR-1:0] o_mem_write_reg,
    output logic [NB_CTRL_WB-1:0]  o_wb_ctrl,
    output logic [NB_REG_ADDR-1:0] o_wb_write_reg,
    output logic                   o_pc_write,
    output logic                   o_ifid_write,
    output logic                   o_flush_ifid,
    output logic                   o_pc_src_branch,
    output logic [NB_COUNT-1:0]    o_bubble_count
);

    logic [NB_CTRL_WB-1:0]  idex_wb_reg,      idex_wb_next;
    logic [NB_CTRL_MEM-1:0] idex_mem_reg,     idex_mem_next;
    logic [NB_CTRL_EX-1:0]  idex_ex_reg,      idex_ex_next;
    logic [NB_REG_ADDR-1:0] idex_rt_reg,      idex_rt_next;
    logic [NB_REG_ADDR-1:0] idex_rd_reg,      idex_rd_next;

    logic [NB_CTRL_WB-1:0]  exmem_wb_reg,     exmem_wb_next;
    logic [NB_CTRL_MEM-1:0] exmem_mem_reg,    exmem_mem_next;
    logic [NB_REG_ADDR-1:0] exmem_dst_reg,    exmem_dst_next;

    logic [NB_CTRL_WB-1:0]  memwb_wb_reg,     memwb_wb_next;
    logic [NB_REG_ADDR-1:0] memwb_dst_reg,    memwb_dst_next;

    logic [NB_COUNT-1:0]    bubble_count_reg, bubble_count_next;

    squash_e squash_cause;
    logic    squash;

    hazard_detection_unit #(
        .NB_REG_ADDR (NB_REG_ADDR)
    ) u_hazard (
        .idex_mem_read (idex_mem_reg[MEMREAD]),
        .idex_branch   (idex_mem_reg[BRANCH]),
        .idex_rt       (idex_rt_reg),
        .id_rs         (i_id_rs),
        .id_rt         (i_id_rt),
        .id_jump       (i_ctrl_ex[JUMP]),
        .alu_zero      (i_alu_zero),
        .pc_write      (o_pc_write),
        .ifid_write    (o_ifid_write),
        .flush_ifid    (o_flush_ifid),
        .pc_src_branch (o_pc_src_branch),
        .squash        (squash_cause)
    );

    assign squash = (squash_cause != SQUASH_NONE);

    always_comb begin
        idex_wb_next      = i_ctrl_wb;
        idex_mem_next     = i_ctrl_mem;
        idex_ex_next      = i_ctrl_ex;
        idex_rt_next      = i_id_rt;
        idex_rd_next      = i_id_rd;
        bubble_count_next = bubble_count_reg;
        if (squash) begin
            idex_wb_next  = {NB_CTRL_WB{BUBBLE_BIT}};
            idex_mem_next = {NB_CTRL_MEM{BUBBLE_BIT}};
            idex_ex_next  = {NB_CTRL_EX{BUBBLE_BIT}};
            idex_rt_next  = {NB_REG_ADDR{BUBBLE_BIT}};
            idex_rd_next  = {NB_REG_ADDR{BUBBLE_BIT}};
            // Saturate rather than wrap so a long run never reads back as few bubbles.
            if (!(&bubble_count_reg)) begin
                bubble_count_next = bubble_count_reg + {{(NB_COUNT-1){1'b0}}, 1'b1};
            end
        end
    end

    // The ex bundle is consumed here; only wb/mem and the destination move on.
    always_comb begin
        exmem_wb_next  = idex_wb_reg;
        exmem_mem_next = idex_mem_reg;
        exmem_dst_next = idex_ex_reg[REGDST] ? idex_rd_reg : idex_rt_reg;
        memwb_wb_next  = exmem_wb_reg;
        memwb_dst_next = exmem_dst_reg;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idex_wb_reg      <= '0;
            idex_mem_reg     <= '0;
            idex_ex_reg      <= '0;
            idex_rt_reg      <= '0;
            idex_rd_reg      <= '0;
            exmem_wb_reg     <= '0;
            exmem_mem_reg    <= '0;
            exmem_dst_reg    <= '0;
            memwb_wb_reg     <= '0;
            memwb_dst_reg    <= '0;
            bubble_count_reg <= '0;
        end else if (i_enable) begin
            idex_wb_reg      <= idex_wb_next;
            idex_mem_reg     <= idex_mem_next;
            idex_ex_reg      <= idex_ex_next;
            idex_rt_reg      <= idex_rt_next;
            idex_rd_reg      <= idex_rd_next;
            exmem_wb_reg     <= exmem_wb_next;
            exmem_mem_reg    <= exmem_mem_next;
            exmem_dst_reg    <= exmem_dst_next;
            memwb_wb_reg     <= memwb_wb_next;
            memwb_dst_reg    <= memwb_dst_next;
            bubble_count_reg <= bubble_count_next;
        end
    end

    assign o_ex_ctrl       = idex_ex_reg;
    assign o_ex_rt         = idex_rt_reg;
    assign o_mem_ctrl      = exmem_mem_reg;
    assign o_mem_write_reg = exmem_dst_reg;
    assign o_wb_ctrl       = memwb_wb_reg;
    assign o_wb_write_reg  = memwb_dst_reg;
    assign o_bubble_count  = bubble_count_reg;

endmodule

// File: tb/tb_control_pipeline.sv
// Bench for control_pipeline: a directed vector table, hand-written
// freeze / async-reset sequences, and randomized traffic against a model.
module tb_control_pipeline;

    typedef struct packed {
        logic       en;
        logic       zero;
        logic [1:0] wb;
        logic [2:0] mem;
        logic [6:0] ex;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } in_t;

    typedef struct packed {
        logic [6:0]  ex_ctrl;
        logic [4:0]  ex_rt;
        logic [2:0]  mem_ctrl;
        logic [4:0]  mem_wr;
        logic [1:0]  wb_ctrl;
        logic [4:0]  wb_wr;
        logic        pc_write;
        logic        ifid_write;
        logic        flush;
        logic        pc_src;
        logic [15:0] count;
    } out_t;

    typedef struct packed {
        in_t  stim;
        out_t exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [1:0]  ctrl_wb;
    logic [2:0]  ctrl_mem;
    logic [6:0]  ctrl_ex;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        alu_zero;
    logic [6:0]  ex_ctrl;
    logic [4:0]  ex_rt;
    logic [2:0]  mem_ctrl;
    logic [4:0]  mem_write_reg;
    logic [1:0]  wb_ctrl;
    logic [4:0]  wb_write_reg;
    logic        pc_write, ifid_write, flush_ifid, pc_src_branch;
    logic [15:0] bubble_count;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    control_pipeline dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_enable        (enable),
        .i_ctrl_wb       (ctrl_wb),
        .i_ctrl_mem      (ctrl_mem),
        .i_ctrl_ex       (ctrl_ex),
        .i_id_rs         (id_rs),
        .i_id_rt         (id_rt),
        .i_id_rd         (id_rd),
        .i_alu_zero      (alu_zero),
        .o_ex_ctrl       (ex_ctrl),
        .o_ex_rt         (ex_rt),
        .o_mem_ctrl      (mem_ctrl),
        .o_mem_write_reg (mem_write_reg),
        .o_wb_ctrl       (wb_ctrl),
        .o_wb_write_reg  (wb_write_reg),
        .o_pc_write      (pc_write),
        .o_ifid_write    (ifid_write),
        .o_flush_ifid    (flush_ifid),
        .o_pc_src_branch (pc_src_branch),
        .o_bubble_count  (bubble_count)
    );

    out_t act;
    assign act = {ex_ctrl, ex_rt, mem_ctrl, mem_write_reg, wb_ctrl, wb_write_reg,
                  pc_write, ifid_write, flush_ifid, pc_src_branch, bubble_count};

    // Reference model: the in-flight instructions as whole records, youngest first
    // ([0] in EX, [1] in MEM, [2] in WB); destinations are derived when observed.
    in_t flight[3];
    int  model_count;

    function automatic in_t mk_in(logic en, logic zero, logic [1:0] wb, logic [2:0] mem,
                                  logic [6:0] ex, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
        in_t v;
        v.en = en; v.zero = zero; v.wb = wb; v.mem = mem; v.ex = ex;
        v.rs = rs; v.rt = rt; v.rd = rd;
        return v;
    endfunction

    function automatic out_t mk_out(logic [6:0] exc, logic [4:0] exrt, logic [2:0] memc,
                                    logic [4:0] memwr, logic [1:0] wbc, logic [4:0] wbwr,
                                    logic pcw, logic ifw, logic fl, logic src, logic [15:0] cnt);
        out_t o;
        o.ex_ctrl = exc; o.ex_rt = exrt; o.mem_ctrl = memc; o.mem_wr = memwr;
        o.wb_ctrl = wbc; o.wb_wr = wbwr; o.pc_write = pcw; o.ifid_write = ifw;
        o.flush = fl; o.pc_src = src; o.count = cnt;
        return o;
    endfunction

    function automatic logic [4:0] dest_of(in_t b);
        return b.ex[6] ? b.rd : b.rt;
    endfunction

    function automatic logic model_load_use(in_t v);
        return flight[0].mem[1] && (flight[0].rt != 5'd0)
               && (flight[0].rt == v.rs || flight[0].rt == v.rt);
    endfunction

    function automatic logic model_taken(in_t v);
        return flight[0].mem[2] && v.zero;
    endfunction

    function automatic out_t model_expect(in_t v);
        logic lu, tk;
        lu = model_load_use(v);
        tk = model_taken(v);
        return mk_out(flight[0].ex, flight[0].rt, flight[1].mem, dest_of(flight[1]),
                      flight[2].wb, dest_of(flight[2]),
                      tk || !lu, tk || !lu, tk || (v.ex[4] && !lu), tk,
                      16'(model_count));
    endfunction

    task automatic model_advance(in_t v);
        logic sq;
        if (!v.en) return;
        sq = model_taken(v) || model_load_use(v);
        flight[2] = flight[1];
        flight[1] = flight[0];
        flight[0] = sq ? in_t'(0) : v;
        if (sq && model_count < 65535) model_count++;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) flight[k] = '0;
        model_count = 0;
    endtask

    function automatic out_t regs_of(out_t o);
        out_t r;
        r = o;
        r.pc_write = 1'b0; r.ifid_write = 1'b0; r.flush = 1'b0; r.pc_src = 1'b0;
        return r;
    endfunction

    task automatic check(string name, out_t got, out_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic drive(in_t v);
        enable   = v.en;
        alu_zero = v.zero;
        ctrl_wb  = v.wb;
        ctrl_mem = v.mem;
        ctrl_ex  = v.ex;
        id_rs    = v.rs;
        id_rt    = v.rt;
        id_rd    = v.rd;
    endtask

    task automatic cycle_model(in_t v, string tag);
        out_t e;
        @(posedge clk);
        #1 drive(v);
        #3;
        e = model_expect(v);
        check(tag, act, e);
        $display("%s in=%h out=%h exp=%h", tag, v, act, e);
        model_advance(v);
    endtask

    function automatic in_t rand_in();
        in_t v;
        v.en     = ($urandom_range(0, 9) != 0);
        v.zero   = ($urandom_range(0, 1) == 1);
        v.wb     = 2'($urandom);
        v.mem[2] = ($urandom_range(0, 3) == 0);
        v.mem[1] = ($urandom_range(0, 2) == 0);
        v.mem[0] = ($urandom_range(0, 1) == 1);
        v.ex     = 7'($urandom);
        v.ex[4]  = ($urandom_range(0, 5) == 0);
        v.rs     = 5'($urandom_range(0, 3));
        v.rt     = 5'($urandom_range(0, 3));
        v.rd     = 5'($urandom);
        return v;
    endfunction

    vec_t tbl[12];
    in_t  r1, nop, lw8, use8, lw0, use0, brl, rt6, jmp;
    out_t snap;
    out_t reset_out;

    initial begin
        r1   = mk_in(1, 0, 2'b10, 3'b000, 7'h42, 5'd1, 5'd3, 5'd5);
        nop  = mk_in(1, 0, 2'b00, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0);
        lw8  = mk_in(1, 0, 2'b11, 3'b010, 7'h20, 5'd2, 5'd8, 5'd0);
        use8 = mk_in(1, 0, 2'b10, 3'b000, 7'h42, 5'd8, 5'd9, 5'd10);
        lw0  = mk_in(1, 0, 2'b11, 3'b010, 7'h20, 5'd2, 5'd0, 5'd0);
        use0 = mk_in(1, 0, 2'b10, 3'b000, 7'h42, 5'd0, 5'd0, 5'd7);
        brl  = mk_in(1, 0, 2'b00, 3'b110, 7'h06, 5'd4, 5'd6, 5'd0);
        rt6  = mk_in(1, 1, 2'b10, 3'b000, 7'h42, 5'd6, 5'd1, 5'd2);
        jmp  = mk_in(1, 0, 2'b00, 3'b000, 7'h10, 5'd0, 5'd0, 5'd0);
        reset_out = mk_out(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);

        tbl[0]  = '{r1,   mk_out(7'h00, 0, 3'b000, 0,  2'b00, 0,  1, 1, 0, 0, 0)};
        tbl[1]  = '{nop,  mk_out(7'h42, 3, 3'b000, 0,  2'b00, 0,  1, 1, 0, 0, 0)};
        tbl[2]  = '{lw8,  mk_out(7'h00, 0, 3'b000, 5,  2'b00, 0,  1, 1, 0, 0, 0)};
        tbl[3]  = '{use8, mk_out(7'h20, 8, 3'b000, 0,  2'b10, 5,  0, 0, 0, 0, 0)};
        tbl[4]  = '{use8, mk_out(7'h00, 0, 3'b010, 8,  2'b00, 0,  1, 1, 0, 0, 1)};
        tbl[5]  = '{lw0,  mk_out(7'h42, 9, 3'b000, 0,  2'b11, 8,  1, 1, 0, 0, 1)};
        tbl[6]  = '{use0, mk_out(7'h20, 0, 3'b000, 10, 2'b00, 0,  1, 1, 0, 0, 1)};
        tbl[7]  = '{brl,  mk_out(7'h42, 0, 3'b010, 0,  2'b10, 10, 1, 1, 0, 0, 1)};
        tbl[8]  = '{rt6,  mk_out(7'h06, 6, 3'b000, 7,  2'b11, 0,  1, 1, 1, 1, 1)};
        tbl[9]  = '{jmp,  mk_out(7'h00, 0, 3'b110, 6,  2'b10, 7,  1, 1, 1, 0, 2)};
        tbl[10] = '{nop,  mk_out(7'h10, 0, 3'b000, 0,  2'b00, 6,  1, 1, 0, 0, 2)};
        tbl[11] = '{nop,  mk_out(7'h00, 0, 3'b000, 0,  2'b00, 0,  1, 1, 0, 0, 2)};

        model_reset();
        rst_n = 1'b0;
        drive(nop);
        repeat (2) @(posedge clk);
        #2 check("reset_state", act, reset_out);
        $display("reset out=%h", act);
        @(negedge clk) rst_n = 1'b1;

        // Directed table; the model is advanced alongside so later phases stay in step.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1 drive(tbl[i].stim);
            #3 check($sformatf("vec%0d", i), act, tbl[i].exp);
            $display("vec%0d in=%h out=%h exp=%h", i, tbl[i].stim, act, tbl[i].exp);
            model_advance(tbl[i].stim);
        end

        // Freeze: three disabled cycles with changing inputs must not move any register.
        cycle_model(r1, "pre_freeze0");
        cycle_model(lw8, "pre_freeze1");
        snap = regs_of(model_expect(nop));
        for (int i = 0; i < 3; i++) begin
            in_t v;
            v = rand_in();
            v.en = 1'b0;
            cycle_model(v, $sformatf("freeze%0d", i));
            check($sformatf("freeze_hold%0d", i), regs_of(act), snap);
        end
        cycle_model(use8, "thaw0");
        cycle_model(use8, "thaw1");

        for (int i = 0; i < 400; i++) begin
            cycle_model(rand_in(), $sformatf("rnd%0d", i));
        end

        // Async reset in the middle of live traffic, observed before any clock edge.
        cycle_model(r1, "pre_rst0");
        cycle_model(lw8, "pre_rst1");
        @(posedge clk);
        #1 drive(nop);
        #2 rst_n = 1'b0;
        #1 check("async_rst", act, reset_out);
        $display("async_rst out=%h", act);
        model_reset();
        @(posedge clk);
        #2 check("rst_held", act, reset_out);
        @(negedge clk) rst_n = 1'b1;
        cycle_model(r1,  "post_rst0");
        cycle_model(nop, "post_rst1");
        cycle_model(nop, "post_rst2");
        cycle_model(nop, "post_rst3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
